instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage that sits directly upstream of the IF/ID pipeline register and so two stages ahead of the ID/EX register. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with a variable-latency response channel. Returned instructions are buffered in a small fetch queue and presented to IF/ID with their PC. It honours a hazard-unit stall and a branch/jump redirect, the same event that drives `flush` downstream.

## Interface
- `PC_WIDTH`, 64, PC and address width.
- `INSTR_WIDTH`, 32, instruction width.
- `RESET_PC`, 64'h0, first fetch address after reset.
- `FQ_DEPTH`, 2, fetch queue entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  PC_WIDTH  fetch address, always word aligned.
- `imem_rsp_valid`  in  1  response data valid.
- `imem_rsp_data`  in  INSTR_WIDTH  fetched instruction.
- `redirect`  in  1  discard all in-flight work and restart at `redirect_pc`.
- `redirect_pc`  in  PC_WIDTH  new fetch address; bits [1:0] ignored (treated as 0).
- `stall`  in  1  IF/ID cannot accept this cycle.
- `inst_valid`  out  1  `inst`/`inst_pc` valid (queue head).
- `inst_pc`  out  PC_WIDTH  PC of head instruction; 0 when queue empty.
- `inst`  out  INSTR_WIDTH  head instruction; 0 when queue empty.

## Operation
- Registers: `pc_reg` (next fetch address), `req_pc` (address of outstanding request), FSM, fetch queue of {pc, instr}.
- At most one request outstanding. Request accepted = `imem_req_valid && imem_req_ready`.
- FSM states:
  - RUN: no request outstanding. `imem_req_valid = (count < FQ_DEPTH)` and `imem_req_addr = pc_reg`. On accept: `req_pc <= pc_reg`, `pc_reg <= pc_reg + 4`, go to WAIT.
  - WAIT: request outstanding, `imem_req_valid = 0`. On `imem_rsp_valid`: push {req_pc, rsp_data}, go to RUN.
  - DRAIN: request outstanding but stale, `imem_req_valid = 0`. On `imem_rsp_valid`: discard the data, go to RUN.
- A queue slot is reserved at acceptance, so a push never meets a full queue.
- Pop occurs when `inst_valid && !stall`. Push and pop in the same cycle are legal and leave count unchanged.
- `stall` blocks only the pop. Fetching continues until the queue is full.
- PC arithmetic is modulo 2^PC_WIDTH; increment at all-ones wraps to 0.
- `redirect` has priority over every other event in its cycle:
  - queue is flushed, with no pop or push that cycle;
  - `pc_reg <= {redirect_pc[PC_WIDTH-1:2], 2'b00}`;
  - next state is DRAIN if a request is outstanding (WAIT, or accepted this cycle), otherwise RUN;
  - a response arriving in the redirect cycle is discarded, and the next state is RUN unless a request was also accepted that cycle.
- A `redirect` in DRAIN keeps the FSM in DRAIN and updates `pc_reg`.
- Reset mid-operation: an outstanding request is forgotten. Memory must not deliver a response for it after reset release; this is a memory-side requirement.

## Timing
- Reset values:
  - `imem_req_valid` 0, `imem_req_addr` RESET_PC;
  - `inst_valid` 0, `inst_pc` 0, `inst` 0;
  - FSM RUN, `pc_reg` RESET_PC, queue empty.
- First cycle after `reset` falls: `imem_req_valid` = 1 with address RESET_PC.
- Response in cycle N: `inst_valid` = 1 in cycle N+1 (registered queue, no bypass).
- With single-cycle memory, peak throughput is one instruction per 2 cycles. The accept→response→re-issue pattern repeats every 2 cycles.
- Redirect in cycle N: `inst_valid` = 0 in N+1. A request to the new PC is issued in N+1 if the FSM is in RUN.
- All outputs are functions of registered state only; no combinational input→output paths.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetch_cnt` (32, increments per push) and `perf_drop_cnt` (32, increments per discarded response or flushed queue entry). Both are reset to 0 and wrap modulo 2^32.
- `FETCH_PERF_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum {RUN, WAIT, DRAIN};
  - `fq_entry_t` struct {pc, instr};
  - constants `PC_STEP = 4` and default `RESET_PC`.
- Sub-module `fetch_queue`: synchronous FIFO of `fq_entry_t`, depth FQ_DEPTH, with push, pop and flush ports and count output. Flush takes priority over push and pop. Reset is asynchronous, active-high.

## Test plan
- Reset release, `imem_req_ready` = 1, 1-cycle memory returning 32'h00000013 → requests at 0x0, 0x4, 0x8 every 2 cycles. `inst_pc` sequence 0x0, 0x4, 0x8 with `inst` = 32'h00000013.
- `stall` held high 10 cycles → at most FQ_DEPTH requests issued. Queue holds 0x0 and 0x4, `imem_req_valid` = 0. After release, pops proceed in order with no loss.
- Redirect to 0x1003 while in WAIT, response arrives next cycle → response dropped. Next request address is 0x1000, `inst_valid` = 0 until 0x1000 returns.
- Redirect in the same cycle as a response and a pop → queue empties, no entry appears for the dropped response, next `inst_pc` = redirect target.
- `redirect_pc` = 64'hFFFF_FFFF_FFFF_FFFC → fetches at ...FFFC then 0x0.
- `reset` asserted while in WAIT with 2 queued entries → all outputs reach their reset values asynchronously. After release, the first request is to RESET_PC. With `FETCH_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned PcWidth    = 64;
  localparam int unsigned InstrWidth = 32;

  localparam logic [PcWidth-1:0] PC_STEP  = 64'd4;
  localparam logic [PcWidth-1:0] RESET_PC = 64'h0;

  // RUN: nothing outstanding; WAIT: live request outstanding; DRAIN: stale request outstanding
  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [PcWidth-1:0]    pc;
    logic [InstrWidth-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response channel.
interface instr_fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32
) ();

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries. Flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  fq_entry_t       push_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fq_entry_t       head_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  fq_entry_t       mem_q [Depth];
  logic            do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CntW'(Depth)) | do_pop);

  // Pointer and occupancy tracking; Depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one-outstanding word fetches, buffers returned
// instructions for IF/ID. Optional FETCH_PERF_EN adds fetch/drop counters.
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = fetch_pkg::PcWidth,
  parameter int unsigned         INSTR_WIDTH = fetch_pkg::InstrWidth,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = fetch_pkg::RESET_PC,
  parameter int unsigned         FQ_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_unit_if.master     imem,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [PC_WIDTH-1:0]    inst_pc,
  output logic [INSTR_WIDTH-1:0] inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_drop_cnt
`endif
);

  import fetch_pkg::*;

  localparam int unsigned     CntW     = $clog2(FQ_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FQ_DEPTH);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic                req_valid_q, req_valid_d;
  logic [CntW-1:0]     count, count_d;
  fq_entry_t           head, push_entry;
  logic                accept, push, pop;
  logic                unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  assign accept     = req_valid_q & imem.imem_req_ready;
  assign inst_valid = (count != '0);
  // Only a live response is kept; redirect suppresses both push and pop
  assign push       = ~redirect & (state_q == WAIT) & imem.imem_rsp_valid;
  assign pop        = ~redirect & inst_valid & ~stall;
  assign push_entry = '{pc: req_pc_q, instr: imem.imem_rsp_data};

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = pc_q;
  assign inst_pc             = inst_valid ? head.pc    : '0;
  assign inst                = inst_valid ? head.instr : '0;

  // Next-state: FSM, PC, and the registered request-valid derived from next occupancy
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          state_d  = redirect ? DRAIN : WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_WIDTH'(PC_STEP);
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) state_d = RUN;
        else if (redirect)       state_d = DRAIN;
      end
      DRAIN: begin
        if (imem.imem_rsp_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (redirect) pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    count_d     = redirect ? '0 : count + CntW'(push) - CntW'(pop);
    // Slot is reserved at issue: only request when the queue will have room
    req_valid_d = (state_d == RUN) && (count_d < DepthCnt);
  end

  // FSM and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  fetch_queue #(
    .Depth (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (head),
    .count_o     (count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, drop_cnt_q;
  logic        drop_rsp;

  assign drop_rsp = imem.imem_rsp_valid &
                    ((state_q == DRAIN) | (redirect & (state_q == WAIT)));

  // Count kept fetches and everything thrown away (stale responses plus flushed entries)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      drop_cnt_q <= drop_cnt_q + (redirect ? 32'(count) : 32'd0) + 32'(drop_rsp);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif

endmodule
